// File: rtl/injector_run_controller.sv
// Run sequencer for massive_traffic_injector: retires queues outside the active
// set, gates the injector for a packet budget, then waits for the stream to drain.
module injector_run_controller #(
    parameter int QUEUE_INDEX_WIDTH = 16,
    parameter int CNT_WIDTH         = 32,
    parameter int DRAIN_IDLE_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_start,
    input  logic                         cfg_abort,
    input  logic [QUEUE_INDEX_WIDTH:0]   cfg_active_queues,
    input  logic [CNT_WIDTH-1:0]         cfg_pkt_budget,
    output logic                         inj_enable,
    output logic [QUEUE_INDEX_WIDTH-1:0] inj_stop_queue_idx,
    output logic                         inj_stop_cmd_valid,
    input  logic                         mon_tvalid,
    input  logic                         mon_tready,
    input  logic                         mon_tlast,
    output logic                         busy,
    output logic                         done,
    output logic                         aborted,
    output logic [CNT_WIDTH-1:0]         pkt_count
);
    localparam int QW = QUEUE_INDEX_WIDTH + 1;
    localparam int IW = $clog2(DRAIN_IDLE_CYCLES + 1);
    localparam logic [QW-1:0]        QUEUE_COUNT = {1'b1, {QUEUE_INDEX_WIDTH{1'b0}}};
    localparam logic [QW-1:0]        SWEEP_STEP  = QW'(32'd1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(32'd1);
    localparam logic [IW-1:0]        IDLE_TARGET = IW'(DRAIN_IDLE_CYCLES);
    localparam logic [IW-1:0]        IDLE_ONE    = IW'(32'd1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SWEEP = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                         r_state;
    logic [QW-1:0]                  r_active;
    logic [CNT_WIDTH-1:0]           r_budget;
    logic [QW-1:0]                  r_sweep_next;
    logic [IW-1:0]                  r_idle_cnt;
    logic                           r_in_pkt;
    logic                           r_enable;
    logic [QUEUE_INDEX_WIDTH-1:0]   r_stop_idx;
    logic                           r_stop_valid;
    logic                           r_busy;
    logic                           r_done;
    logic                           r_aborted;
    logic [CNT_WIDTH-1:0]           r_pkt_count;

    logic                           w_beat;
    logic                           w_pkt_done;
    logic [CNT_WIDTH-1:0]           w_cnt_inc;
    logic                           w_in_pkt_next;
    logic [IW-1:0]                  w_idle_next;
    logic                           w_sweep_last;
    logic                           w_budget_hit;
    logic                           w_start_full;

    // Stream observation, saturating packet count and sweep/idle bookkeeping
    always_comb begin
        w_beat     = mon_tvalid & mon_tready;
        w_pkt_done = w_beat & mon_tlast;
        if (w_pkt_done && (r_pkt_count != CNT_MAX)) begin
            w_cnt_inc = r_pkt_count + CNT_ONE;
        end else begin
            w_cnt_inc = r_pkt_count;
        end
        if (w_beat) begin
            w_in_pkt_next = ~mon_tlast;
        end else begin
            w_in_pkt_next = r_in_pkt;
        end
        // A stalled beat or an open packet is not idle, even with tvalid low
        if (!mon_tvalid && !r_in_pkt) begin
            w_idle_next = r_idle_cnt + IDLE_ONE;
        end else begin
            w_idle_next = '0;
        end
        w_sweep_last = (r_sweep_next == QUEUE_COUNT);
        w_budget_hit = (w_cnt_inc >= r_budget);
        w_start_full = (cfg_active_queues == QUEUE_COUNT);
    end

    // Run state machine with registered injector controls and status
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_active     <= '0;
            r_budget     <= '0;
            r_sweep_next <= '0;
            r_idle_cnt   <= '0;
            r_in_pkt     <= 1'b0;
            r_enable     <= 1'b0;
            r_stop_idx   <= '0;
            r_stop_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_pkt_count  <= '0;
        end else begin
            r_in_pkt <= w_in_pkt_next;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (cfg_start) begin
                        r_active    <= cfg_active_queues;
                        r_budget    <= cfg_pkt_budget;
                        r_pkt_count <= '0;
                        r_aborted   <= 1'b0;
                        r_idle_cnt  <= '0;
                        if (w_start_full) begin
                            if (cfg_pkt_budget == '0) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state  <= S_RUN;
                                r_enable <= 1'b1;
                                r_done   <= 1'b0;
                                r_busy   <= 1'b1;
                            end
                        end else begin
                            r_state      <= S_SWEEP;
                            r_stop_valid <= 1'b1;
                            r_stop_idx   <= cfg_active_queues[QUEUE_INDEX_WIDTH-1:0];
                            r_sweep_next <= cfg_active_queues + SWEEP_STEP;
                            r_done       <= 1'b0;
                            r_busy       <= 1'b1;
                        end
                    end else begin
                        r_state <= r_state;
                    end
                end
                S_SWEEP: begin
                    if (cfg_abort) begin
                        r_state      <= S_DRAIN;
                        r_stop_valid <= 1'b0;
                        r_aborted    <= 1'b1;
                        r_idle_cnt   <= '0;
                    end else if (w_sweep_last) begin
                        r_stop_valid <= 1'b0;
                        if ((r_budget == '0) || (r_active == '0)) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state  <= S_RUN;
                            r_enable <= 1'b1;
                        end
                    end else begin
                        r_stop_idx   <= r_sweep_next[QUEUE_INDEX_WIDTH-1:0];
                        r_sweep_next <= r_sweep_next + SWEEP_STEP;
                    end
                end
                S_RUN: begin
                    r_pkt_count <= w_cnt_inc;
                    if (cfg_abort) begin
                        r_state    <= S_DRAIN;
                        r_enable   <= 1'b0;
                        r_aborted  <= 1'b1;
                        r_idle_cnt <= '0;
                    end else if (w_budget_hit) begin
                        r_state    <= S_DRAIN;
                        r_enable   <= 1'b0;
                        r_idle_cnt <= '0;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_DRAIN: begin
                    r_pkt_count <= w_cnt_inc;
                    if (cfg_abort) begin
                        r_aborted <= 1'b1;
                    end else begin
                        r_aborted <= r_aborted;
                    end
                    if (w_idle_next == IDLE_TARGET) begin
                        r_state    <= S_DONE;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_idle_cnt <= '0;
                    end else begin
                        r_idle_cnt <= w_idle_next;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_enable     <= 1'b0;
                    r_stop_valid <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign inj_enable         = r_enable;
    assign inj_stop_queue_idx = r_stop_idx;
    assign inj_stop_cmd_valid = r_stop_valid;
    assign busy               = r_busy;
    assign done               = r_done;
    assign aborted            = r_aborted;
    assign pkt_count          = r_pkt_count;

endmodule

// File: doc/injector_run_controller.md
Name: injector_run_controller

Overview:
Sequences one measurement run of massive_traffic_injector. The block takes a run configuration (number of active queues, packet budget). It issues stop commands to retire every queue outside the active set, then asserts the injector enable. It counts completed packets on the injector's AXI-Stream output and drops enable once the budget is reached. It then waits for the stream to go idle before reporting done.

Parameters:
QUEUE_INDEX_WIDTH, 16, width of queue index; QUEUE_COUNT = 2**QUEUE_INDEX_WIDTH
CNT_WIDTH, 32, width of packet budget and packet counter
DRAIN_IDLE_CYCLES, 64, consecutive idle cycles required to declare the stream drained (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_start  in  1  one-cycle pulse; latches config and starts a run when idle
cfg_abort  in  1  one-cycle pulse; ends a run early
cfg_active_queues  in  QUEUE_INDEX_WIDTH+1  queues 0..N-1 stay active; range 0..QUEUE_COUNT
cfg_pkt_budget  in  CNT_WIDTH  packets to allow before stopping
inj_enable  out  1  drives injector enable
inj_stop_queue_idx  out  QUEUE_INDEX_WIDTH  queue index of the stop command
inj_stop_cmd_valid  out  1  stop command strobe, one queue per cycle
mon_tvalid  in  1  tap of injector m_axis_pkt_tvalid
mon_tready  in  1  tap of sink m_axis_pkt_tready
mon_tlast  in  1  tap of injector m_axis_pkt_tlast
busy  out  1  high in SWEEP/RUN/DRAIN
done  out  1  sticky; high in DONE
aborted  out  1  sticky; set if the run ended via cfg_abort
pkt_count  out  CNT_WIDTH  packets completed this run, saturating

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; latched config 0.
- Beat = mon_tvalid & mon_tready. Packet completes on beat & mon_tlast.
- pkt_count increments per completed packet in RUN and DRAIN and saturates at 2**CNT_WIDTH-1.
- in_pkt flag: set on a beat with !tlast, cleared on a beat with tlast.
- States and transitions:
  - IDLE: cfg_start latches cfg_active_queues (A) and cfg_pkt_budget (B), clears pkt_count/done/aborted, and moves to SWEEP. All of this is registered, so the first stop strobe appears the cycle after cfg_start. If A == QUEUE_COUNT, go straight to RUN instead.
  - SWEEP: inj_stop_cmd_valid=1 and inj_stop_queue_idx=sweep_idx, starting at A and incrementing each cycle. After the strobe for QUEUE_COUNT-1, go to RUN, or to DONE if B==0 or A==0. The compare uses width QUEUE_INDEX_WIDTH+1, so there is no wrap. Exactly QUEUE_COUNT-A strobes are issued.
  - RUN: inj_enable=1. Entering RUN with B==0 goes to DONE without asserting enable. When pkt_count reaches B (including on a completion cycle), inj_enable drops the next cycle and the block goes to DRAIN.
  - DRAIN: inj_enable=0. An idle counter counts cycles with !mon_tvalid & !in_pkt and resets to 0 on any other cycle. At DRAIN_IDLE_CYCLES the block goes to DONE.
  - DONE: done=1, busy=0. cfg_start behaves as in IDLE, so DONE->SWEEP/RUN directly.
- cfg_abort:
  - In SWEEP or RUN: immediate move to DRAIN; sets aborted; remaining sweep strobes are not issued.
  - In DRAIN: sets aborted only.
  - In IDLE or DONE: ignored.
- cfg_start while busy: ignored. If cfg_start and cfg_abort arrive in the same cycle in IDLE, start wins and abort is ignored.
- Overshoot: packets completing in DRAIN still count, so pkt_count may exceed B.
- Reset mid-run: all state cleared in one cycle; enable and stop strobe low on the next edge. Queues already stopped are not restored; software resets the injector.
- inj_stop_queue_idx holds its last value when the strobe is low.

Test Plan:
- QUEUE_INDEX_WIDTH=4, A=12, B=5, sink always ready, 3-beat packets -> exactly 4 strobes with idx 12,13,14,15 on consecutive cycles. Enable rises the cycle after idx 15, pkt_count=5 when enable falls, done after 64 idle cycles, aborted=0.
- A=16, B=3 -> zero stop strobes; RUN entered the cycle after start; pkt_count=3; done=1.
- B=0, A=8 -> 8 strobes (idx 8..15); inj_enable never asserted; done=1; pkt_count=0.
- Budget hit mid-stream with tready toggling 50% -> enable drops after the 3rd tlast. A packet in flight keeps the idle counter at 0 until its tlast. Overshoot packets are counted and done arrives late.
- cfg_abort during SWEEP at idx 13 (A=12) -> no strobe for 14,15; DRAIN; done=1 with aborted=1. A second cfg_start while busy is ignored.
- rst asserted in RUN -> next cycle inj_enable=0, busy=0, pkt_count=0. A subsequent start with A=14, B=2 completes normally.
